// File: rtl/esc_pwm_gen_if.sv
// Control/status bundle between the ESC control logic and the PWM generator.
// The controller holds the master side; esc_pwm_gen holds the slave side.
interface esc_pwm_gen_if #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 12,
    parameter int DT_W  = 8
);
    logic                    en;
    logic [CNT_W-1:0]        period_in;
    logic [N_CH*CNT_W-1:0]   duty_in;
    logic                    load;
    logic                    load_ack;
    logic [DT_W-1:0]         dt_cycles;
    logic [CNT_W-1:0]        cnt;
    logic                    period_start;
    logic [N_CH-1:0]         pwm_h;
    logic [N_CH-1:0]         pwm_l;

    modport master (
        output en, period_in, duty_in, load, dt_cycles,
        input  load_ack, cnt, period_start, pwm_h, pwm_l
    );

    modport slave (
        input  en, period_in, duty_in, load, dt_cycles,
        output load_ack, cnt, period_start, pwm_h, pwm_l
    );
endinterface

// File: rtl/esc_pwm_gen.sv
// Multi-channel PWM generator: shared edge/centre-aligned counter, per-channel compare,
// shadow-buffered period/duty. Define DEADTIME_EN to add per-channel rising-edge dead-time.
module esc_pwm_gen #(
    parameter int N_CH       = 3,
    parameter int CNT_W      = 12,
    parameter bit CENTER     = 1'b0,
    parameter int PERIOD_RST = 1250,
    parameter int DT_W       = 8
) (
    input logic          clk_ctrl,
    input logic          rst_n,
    esc_pwm_gen_if.slave bus
);
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(2);
    localparam logic [CNT_W-1:0] PERIOD_INIT = (PERIOD_RST < 2) ? PERIOD_MIN : CNT_W'(PERIOD_RST);

    dir_e                  dir_q, dir_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [N_CH*CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]      shadowPeriod_q, shadowPeriod_d;
    logic [N_CH*CNT_W-1:0] shadowDuty_q, shadowDuty_d;
    logic                  pending_q, pending_d;
    logic                  loadAck_q, loadAck_d;
    logic                  periodStart_q, periodStart_d;
    logic [N_CH-1:0]       pwmH_q, pwmH_d;
    logic [N_CH-1:0]       pwmL_q, pwmL_d;
    logic [N_CH-1:0]       raw;
    logic                  atBoundary;
    logic                  applyShadow;

    // Counter sequencing, compare and shadow handover. The boundary is the last cycle
    // of a period, so new settings take effect exactly as cnt returns to 0.
    always_comb begin
        cnt_d          = cnt_q;
        dir_d          = dir_q;
        period_d       = period_q;
        duty_d         = duty_q;
        shadowPeriod_d = shadowPeriod_q;
        shadowDuty_d   = shadowDuty_q;
        pending_d      = pending_q;
        loadAck_d      = 1'b0;
        raw            = '0;
        atBoundary     = 1'b0;
        applyShadow    = 1'b0;

        for (int i = 0; i < N_CH; i++) begin
            raw[i] = cnt_q < duty_q[i*CNT_W +: CNT_W];
        end

        if (CENTER) begin
            atBoundary = (dir_q == DIR_DOWN) && (cnt_q == CNT_W'(1));
        end else begin
            atBoundary = cnt_q >= (period_q - CNT_W'(1));
        end

        if (!bus.en) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (CENTER) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_W'(1);
                dir_d = DIR_UP;
            end else if ((dir_q == DIR_UP) && (cnt_q >= period_q)) begin
                cnt_d = cnt_q - CNT_W'(1);
                dir_d = DIR_DOWN;
            end else if (dir_q == DIR_UP) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            cnt_d = atBoundary ? '0 : cnt_q + CNT_W'(1);
        end

        // period_start shares the one-cycle latency of the compare outputs.
        periodStart_d = bus.en && (cnt_q == '0);

        applyShadow = pending_q && (atBoundary || !bus.en);
        if (applyShadow) begin
            period_d  = (shadowPeriod_q < PERIOD_MIN) ? PERIOD_MIN : shadowPeriod_q;
            duty_d    = shadowDuty_q;
            pending_d = 1'b0;
            loadAck_d = 1'b1;
        end

        if (bus.load) begin
            shadowPeriod_d = bus.period_in;
            shadowDuty_d   = bus.duty_in;
            pending_d      = 1'b1;
        end
    end

`ifdef DEADTIME_EN
    logic [N_CH-1:0] rawPrev_q;
    logic [DT_W-1:0] dtCnt_q [N_CH];
    logic [DT_W-1:0] dtCnt_d [N_CH];

    // Every raw edge restarts the hold-off; an output may only rise once it expires,
    // so high and low sides are both off for dt_cycles around each transition.
    always_comb begin
        pwmH_d = '0;
        pwmL_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (raw[i] != rawPrev_q[i]) begin
                dtCnt_d[i] = bus.dt_cycles;
            end else if (dtCnt_q[i] != '0) begin
                dtCnt_d[i] = dtCnt_q[i] - DT_W'(1);
            end else begin
                dtCnt_d[i] = '0;
            end
            pwmH_d[i] = bus.en && raw[i] && (dtCnt_d[i] == '0);
            pwmL_d[i] = bus.en && !raw[i] && (dtCnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            rawPrev_q <= '0;
            for (int i = 0; i < N_CH; i++) dtCnt_q[i] <= '0;
        end else begin
            rawPrev_q <= raw;
            for (int i = 0; i < N_CH; i++) dtCnt_q[i] <= dtCnt_d[i];
        end
    end
`else
    logic [DT_W-1:0] unusedDt;
    assign unusedDt = bus.dt_cycles;

    always_comb begin
        pwmH_d = {N_CH{bus.en}} & raw;
        pwmL_d = {N_CH{bus.en}} & ~raw;
    end
`endif

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            dir_q          <= DIR_UP;
            cnt_q          <= '0;
            period_q       <= PERIOD_INIT;
            duty_q         <= '0;
            shadowPeriod_q <= '0;
            shadowDuty_q   <= '0;
            pending_q      <= 1'b0;
            loadAck_q      <= 1'b0;
            periodStart_q  <= 1'b0;
            pwmH_q         <= '0;
            pwmL_q         <= '0;
        end else begin
            dir_q          <= dir_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            duty_q         <= duty_d;
            shadowPeriod_q <= shadowPeriod_d;
            shadowDuty_q   <= shadowDuty_d;
            pending_q      <= pending_d;
            loadAck_q      <= loadAck_d;
            periodStart_q  <= periodStart_d;
            pwmH_q         <= pwmH_d;
            pwmL_q         <= pwmL_d;
        end
    end

    assign bus.cnt          = cnt_q;
    assign bus.load_ack     = loadAck_q;
    assign bus.period_start = periodStart_q;
    assign bus.pwm_h        = pwmH_q;
    assign bus.pwm_l        = pwmL_q;
endmodule

// File: tb/tb_esc_pwm_gen.sv
// Bench for esc_pwm_gen: an edge-aligned and a centre-aligned instance share randomized
// stimulus; a phase-based reference model feeds per-instance scoreboards checked by a monitor.
module tb_esc_pwm_gen;
    localparam int N_CH       = 3;
    localparam int CNT_W      = 12;
    localparam int DT_W       = 8;
    localparam int PERIOD_RST = 1250;

    typedef struct {
        int              cnt;
        bit              ps;
        bit              ack;
        bit [N_CH-1:0]   h;
        bit [N_CH-1:0]   l;
    } expect_t;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    esc_pwm_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) busEdge ();
    esc_pwm_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) busCentre ();

    esc_pwm_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .CENTER(1'b0), .PERIOD_RST(PERIOD_RST), .DT_W(DT_W))
        dutEdge (.clk_ctrl(clk), .rst_n(rstN), .bus(busEdge));
    esc_pwm_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .CENTER(1'b1), .PERIOD_RST(PERIOD_RST), .DT_W(DT_W))
        dutCentre (.clk_ctrl(clk), .rst_n(rstN), .bus(busCentre));

    int      compared   = 0;
    int      mismatched = 0;
    expect_t qEdge[$];
    expect_t qCentre[$];
    expect_t monEdge, monCentre, zeroExp;

    // Reference model: position within the period instead of counter/direction state.
    int actP  [2];
    int actD  [2][N_CH];
    int shP   [2];
    int shD   [2][N_CH];
    bit pend  [2];
    int phase [2];
    int stimD [N_CH];

    function automatic void modelReset();
        for (int m = 0; m < 2; m++) begin
            actP[m]  = PERIOD_RST;
            shP[m]   = 0;
            pend[m]  = 1'b0;
            phase[m] = 0;
            for (int i = 0; i < N_CH; i++) begin
                actD[m][i] = 0;
                shD[m][i]  = 0;
            end
        end
    endfunction

    function automatic int periodLen(input int m);
        return (m == 0) ? actP[m] : 2 * actP[m];
    endfunction

    function automatic int modelCnt(input int m);
        if (m == 0) return phase[m];
        return (phase[m] <= actP[m]) ? phase[m] : 2 * actP[m] - phase[m];
    endfunction

    function automatic expect_t modelStep(input int m, input bit en, input bit ld, input int pIn);
        expect_t e;
        int      c;
        bit      bnd;
        bit      apply;
        c     = modelCnt(m);
        e.ps  = en && (c == 0);
        for (int i = 0; i < N_CH; i++) begin
            e.h[i] = en && (c < actD[m][i]);
            e.l[i] = en && !(c < actD[m][i]);
        end
        bnd   = en && (phase[m] == periodLen(m) - 1);
        apply = pend[m] && (bnd || !en);
        e.ack = apply;
        phase[m] = (!en || bnd) ? 0 : phase[m] + 1;
        if (apply) begin
            actP[m] = (shP[m] < 2) ? 2 : shP[m];
            for (int i = 0; i < N_CH; i++) actD[m][i] = shD[m][i];
            pend[m] = 1'b0;
        end
        if (ld) begin
            shP[m] = pIn;
            for (int i = 0; i < N_CH; i++) shD[m][i] = stimD[i];
            pend[m] = 1'b1;
        end
        e.cnt = modelCnt(m);
        return e;
    endfunction

    task automatic compareField(input string tag, input string name,
                                input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s.%s at %0t: got %0d expected %0d", tag, name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input expect_t e, input logic [CNT_W-1:0] aCnt,
                               input logic aPs, input logic aAck,
                               input logic [N_CH-1:0] aH, input logic [N_CH-1:0] aL);
        compareField(tag, "cnt", 32'(aCnt), 32'(e.cnt));
        compareField(tag, "period_start", 32'(aPs), 32'(e.ps));
        compareField(tag, "load_ack", 32'(aAck), 32'(e.ack));
        compareField(tag, "pwm_h", 32'(aH), 32'(e.h));
        compareField(tag, "pwm_l", 32'(aL), 32'(e.l));
        compareField(tag, "hlOverlap", 32'(aH & aL), 32'd0);
    endtask

    // Drive one cycle of inputs on the falling edge and queue what both instances owe.
    task automatic applyStimulus(input bit enV, input bit loadV, input int pV);
        logic [N_CH*CNT_W-1:0] dutyVec;
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) dutyVec[i*CNT_W +: CNT_W] = stimD[i][CNT_W-1:0];
        busEdge.en          = enV;
        busEdge.load        = loadV;
        busEdge.period_in   = pV[CNT_W-1:0];
        busEdge.duty_in     = dutyVec;
        busEdge.dt_cycles   = '0;
        busCentre.en        = enV;
        busCentre.load      = loadV;
        busCentre.period_in = pV[CNT_W-1:0];
        busCentre.duty_in   = dutyVec;
        busCentre.dt_cycles = '0;
        qEdge.push_back(modelStep(0, enV, loadV, pV));
        qCentre.push_back(modelStep(1, enV, loadV, pV));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Edge"}, zeroExp, busEdge.cnt, busEdge.period_start, busEdge.load_ack,
                    busEdge.pwm_h, busEdge.pwm_l);
        checkOutput({tag, "Centre"}, zeroExp, busCentre.cnt, busCentre.period_start,
                    busCentre.load_ack, busCentre.pwm_h, busCentre.pwm_l);
    endtask

    task automatic runBoundaryLoad(input int m);
        int budget = 3000;
        while (phase[m] != periodLen(m) - 1 && budget > 0) begin
            applyStimulus(1'b1, 1'b0, 0);
            budget--;
        end
        if (budget == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL boundaryWait%0d: got timeout expected boundary", m);
        end
        for (int i = 0; i < N_CH; i++) stimD[i] = $urandom_range(0, 14);
        applyStimulus(1'b1, 1'b1, $urandom_range(3, 12));
        repeat (40) applyStimulus(1'b1, 1'b0, 0);
    endtask

    // Monitor: every cycle on which an expectation is queued, the outputs are compared.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qEdge.size() > 0) begin
                monEdge = qEdge.pop_front();
                checkOutput("edge", monEdge, busEdge.cnt, busEdge.period_start, busEdge.load_ack,
                            busEdge.pwm_h, busEdge.pwm_l);
            end
            if (qCentre.size() > 0) begin
                monCentre = qCentre.pop_front();
                checkOutput("centre", monCentre, busCentre.cnt, busCentre.period_start,
                            busCentre.load_ack, busCentre.pwm_h, busCentre.pwm_l);
            end
        end
    end

    initial begin
        zeroExp = '{cnt: 0, ps: 1'b0, ack: 1'b0, h: '0, l: '0};
        rstN = 1'b0;
        for (int i = 0; i < N_CH; i++) stimD[i] = 0;
        busEdge.en = 1'b0;   busEdge.load = 1'b0;   busEdge.period_in = '0;
        busEdge.duty_in = '0;   busEdge.dt_cycles = '0;
        busCentre.en = 1'b0; busCentre.load = 1'b0; busCentre.period_in = '0;
        busCentre.duty_in = '0; busCentre.dt_cycles = '0;
        modelReset();

        #12;
        checkResetState("reset");
        @(posedge clk);
        #3 rstN = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 0);
        repeat (5) applyStimulus(1'b1, 1'b0, 0);

        // Reset period runs out, then P=10 with duties 3 / 0 / 12 takes over.
        stimD = '{3, 0, 12};
        applyStimulus(1'b1, 1'b1, 10);
        repeat (2600) applyStimulus(1'b1, 1'b0, 0);

        // Two loads inside one period: only the last one lands.
        repeat (3) applyStimulus(1'b1, 1'b0, 0);
        stimD = '{5, 9, 1};
        applyStimulus(1'b1, 1'b1, 20);
        repeat (2) applyStimulus(1'b1, 1'b0, 0);
        stimD = '{4, 8, 2};
        applyStimulus(1'b1, 1'b1, 8);
        repeat (60) applyStimulus(1'b1, 1'b0, 0);

        stimD = '{2, 5, 7};
        applyStimulus(1'b1, 1'b1, 6);
        repeat (60) applyStimulus(1'b1, 1'b0, 0);

        stimD = '{1, 2, 3};
        applyStimulus(1'b1, 1'b1, 0);
        repeat (30) applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1);
        repeat (30) applyStimulus(1'b1, 1'b0, 0);

        runBoundaryLoad(0);
        runBoundaryLoad(1);
        runBoundaryLoad(0);

        repeat (5) applyStimulus(1'b1, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 0);
        repeat (10) applyStimulus(1'b1, 1'b0, 0);

        repeat (2000) begin
            if ($urandom_range(0, 99) < 6) begin
                for (int i = 0; i < N_CH; i++) stimD[i] = $urandom_range(0, 20);
                applyStimulus($urandom_range(0, 99) < 95, 1'b1, $urandom_range(0, 16));
            end else begin
                applyStimulus($urandom_range(0, 99) < 95, 1'b0, 0);
            end
        end

        // Asynchronous reset in the middle of a high pulse.
        stimD = '{8, 8, 8};
        applyStimulus(1'b1, 1'b1, 15);
        repeat (80) applyStimulus(1'b1, 1'b0, 0);
        @(posedge clk);
        #3 rstN = 1'b0;
        #1 checkResetState("asyncReset");
        modelReset();
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        repeat (1300) applyStimulus(1'b1, 1'b0, 0);

        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (qEdge.size() != 0 || qCentre.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d queued expected 0", qEdge.size() + qCentre.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
